// File: rtl/chunked_addsub_if.sv
// Start/done handshake, operands and status flags of the chunked add/subtract unit.
// The master side issues operations; the slave side is the arithmetic block.
interface chunked_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered inter-chunk carry.
// Results and flags update only on the completion edge, together with a one-cycle done pulse.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             rst,
  chunked_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_done;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK+1:0] w_rip;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt;

  // Per-bit ripple over one slice; returns {carry into slice MSB, carry out, sum}.
  function automatic logic [CHUNK+1:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             cin);
    logic             c;
    logic             cm;
    logic [CHUNK-1:0] s;
    c  = cin;
    cm = cin;
    s  = '0;
    for (int k = 0; k < CHUNK; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      cm   = c;
      c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
    end
    return {cm, c, s};
  endfunction

  always_comb begin
    w_rip     = ripple(r_a[int'(r_idx)*CHUNK +: CHUNK], r_b[int'(r_idx)*CHUNK +: CHUNK], r_carry);
    w_sum     = w_rip[CHUNK-1:0];
    w_cout    = w_rip[CHUNK];
    w_cin_msb = w_rip[CHUNK+1];
    w_last    = (r_idx == IW'(N - 1));
    w_acc_nxt = r_acc;
    w_acc_nxt[int'(r_idx)*CHUNK +: CHUNK] = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Subtraction is a + ~b + 1: invert B once here and seed the carry with sub.
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.sub}};
            r_carry <= bus.sub;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_cout;
          if (w_last) begin
            r_idx    <= '0;
            r_result <= w_acc_nxt;
            r_c_out  <= w_cout;
            r_ovf    <= w_cin_msb ^ w_cout;
            r_zero   <= (w_acc_nxt == '0);
            r_done   <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.c_out    = r_c_out;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: five configurations share one stimulus stream and are
// compared against a plain-arithmetic reference model.
module tb_chunked_addsub;
  logic        clk = 1'b0;
  logic        rst;
  logic        t_start;
  logic        t_sub;
  logic [31:0] t_a;
  logic [31:0] t_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Configurations: 32/8, 32/1, 32/4, 32/32, 16/4
  int cfg_w[5] = '{32, 32, 32, 32, 16};
  int cfg_n[5] = '{4, 32, 8, 1, 4};

  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(32)) bus0 ();
  chunked_addsub_if #(.WIDTH(32)) bus1 ();
  chunked_addsub_if #(.WIDTH(32)) bus2 ();
  chunked_addsub_if #(.WIDTH(32)) bus3 ();
  chunked_addsub_if #(.WIDTH(16)) bus4 ();

  chunked_addsub #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .rst(rst), .bus(bus0));
  chunked_addsub #(.WIDTH(32), .CHUNK(1))  u1 (.clk(clk), .rst(rst), .bus(bus1));
  chunked_addsub #(.WIDTH(32), .CHUNK(4))  u2 (.clk(clk), .rst(rst), .bus(bus2));
  chunked_addsub #(.WIDTH(32), .CHUNK(32)) u3 (.clk(clk), .rst(rst), .bus(bus3));
  chunked_addsub #(.WIDTH(16), .CHUNK(4))  u4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus0.start = t_start; assign bus0.sub = t_sub; assign bus0.a = t_a;        assign bus0.b = t_b;
  assign bus1.start = t_start; assign bus1.sub = t_sub; assign bus1.a = t_a;        assign bus1.b = t_b;
  assign bus2.start = t_start; assign bus2.sub = t_sub; assign bus2.a = t_a;        assign bus2.b = t_b;
  assign bus3.start = t_start; assign bus3.sub = t_sub; assign bus3.a = t_a;        assign bus3.b = t_b;
  assign bus4.start = t_start; assign bus4.sub = t_sub; assign bus4.a = t_a[15:0];  assign bus4.b = t_b[15:0];

  logic [31:0] o_res  [5];
  logic        o_busy [5];
  logic        o_done [5];
  logic        o_c    [5];
  logic        o_v    [5];
  logic        o_z    [5];

  assign o_res[0] = bus0.result; assign o_busy[0] = bus0.busy; assign o_done[0] = bus0.done;
  assign o_c[0] = bus0.c_out; assign o_v[0] = bus0.overflow; assign o_z[0] = bus0.zero;
  assign o_res[1] = bus1.result; assign o_busy[1] = bus1.busy; assign o_done[1] = bus1.done;
  assign o_c[1] = bus1.c_out; assign o_v[1] = bus1.overflow; assign o_z[1] = bus1.zero;
  assign o_res[2] = bus2.result; assign o_busy[2] = bus2.busy; assign o_done[2] = bus2.done;
  assign o_c[2] = bus2.c_out; assign o_v[2] = bus2.overflow; assign o_z[2] = bus2.zero;
  assign o_res[3] = bus3.result; assign o_busy[3] = bus3.busy; assign o_done[3] = bus3.done;
  assign o_c[3] = bus3.c_out; assign o_v[3] = bus3.overflow; assign o_z[3] = bus3.zero;
  assign o_res[4] = {16'h0, bus4.result}; assign o_busy[4] = bus4.busy; assign o_done[4] = bus4.done;
  assign o_c[4] = bus4.c_out; assign o_v[4] = bus4.overflow; assign o_z[4] = bus4.zero;

  // Reference: integer add/sub on w-bit values; returns {result, c_out, overflow, zero}.
  function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic sub);
    longint lim, half, ua, ub, sa, sb, ur, exact;
    logic [31:0] r;
    logic c, v, z;
    lim   = longint'(1) << w;
    half  = lim / 2;
    ua    = longint'(a) & (lim - 1);
    ub    = longint'(b) & (lim - 1);
    sa    = (ua >= half) ? ua - lim : ua;
    sb    = (ub >= half) ? ub - lim : ub;
    ur    = sub ? ua - ub : ua + ub;
    exact = sub ? sa - sb : sa + sb;
    c     = sub ? (ua >= ub) : (ur >= lim);
    v     = (exact >= half) || (exact < -half);
    r     = 32'(ur & (lim - 1));
    z     = (r == 32'h0);
    return {r, c, v, z};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    t_a = a; t_b = b; t_sub = sub; t_start = 1'b1;
    tick();
    t_start = 1'b0;
  endtask

  function automatic logic any_busy();
    logic r = 1'b0;
    for (int i = 0; i < 5; i++) r |= o_busy[i];
    return r;
  endfunction

  task automatic wait_idle();
    int c = 0;
    while (any_busy() && c < 40) begin tick(); c++; end
    n_checks++;
    if (any_busy() !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", any_busy(), c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; t_start = 1'b0; t_sub = 1'b0; t_a = '0; t_b = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i]} !== 37'h0) begin
        n_fail++;
        $display("FAIL reset_state cfg%0d: busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                 i, o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int first = 0;
    int pulses = 0;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    n_checks++;
    if (o_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_busy: busy=%b, required 1", o_busy[0]);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (o_done[0] === 1'b1) begin pulses++; if (first == 0) first = c; end
    end
    n_checks++;
    if (first != 4) begin n_fail++; $display("FAIL ovf_latency: done at edge %0d, required 4", first); end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL ovf_pulse: %0d done cycles, required 1", pulses); end
    n_checks++;
    if ({o_res[0], o_c[0], o_v[0], o_z[0]} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_result: res=%h c=%b v=%b z=%b, required 80000000 c=0 v=1 z=0",
               o_res[0], o_c[0], o_v[0], o_z[0]);
    end
    wait_idle();
  endtask

  task automatic test_wrap();
    logic [31:0] ta[3]   = '{32'hFFFF_FFFF, 32'd5, 32'd3};
    logic [31:0] tbv[3]  = '{32'd1, 32'd5, 32'd5};
    logic        ts[3]   = '{1'b0, 1'b1, 1'b1};
    logic [31:0] er[3]   = '{32'h0, 32'h0, 32'hFFFF_FFFE};
    logic        ec[3]   = '{1'b1, 1'b1, 1'b0};
    logic        ez[3]   = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      issue(ta[k], tbv[k], ts[k]);
      wait_idle();
      n_checks++;
      if ({o_res[0], o_c[0], o_v[0], o_z[0]} !== {er[k], ec[k], 1'b0, ez[k]}) begin
        n_fail++;
        $display("FAIL wrap%0d: res=%h c=%b v=%b z=%b, required %h c=%b v=0 z=%b",
                 k, o_res[0], o_c[0], o_v[0], o_z[0], er[k], ec[k], ez[k]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int c;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    tick();
    t_a = 32'hDEAD_BEEF; t_b = 32'h1; t_sub = 1'b1; t_start = 1'b1;
    tick();
    t_start = 1'b0;
    c = 2;
    while (o_done[0] !== 1'b1 && c < 10) begin tick(); c++; end
    n_checks++;
    if (c != 4) begin n_fail++; $display("FAIL busy_start_latency: done at edge %0d, required 4", c); end
    n_checks++;
    if ({o_res[0], o_c[0], o_v[0], o_z[0]} !== {32'h2345_6789, 3'b000}) begin
      n_fail++;
      $display("FAIL busy_start_result: res=%h c=%b v=%b z=%b, required 23456789 c=0 v=0 z=0",
               o_res[0], o_c[0], o_v[0], o_z[0]);
    end
    // Start in the done cycle must be accepted without a bubble.
    t_a = 32'd100; t_b = 32'd30; t_sub = 1'b1; t_start = 1'b1;
    tick();
    t_start = 1'b0;
    c = 0;
    while (o_done[0] !== 1'b1 && c < 10) begin tick(); c++; end
    n_checks++;
    if (c != 4) begin n_fail++; $display("FAIL b2b_latency: done at edge %0d, required 4", c); end
    n_checks++;
    if ({o_res[0], o_c[0], o_v[0], o_z[0]} !== {32'd70, 3'b100}) begin
      n_fail++;
      $display("FAIL b2b_result: res=%h c=%b v=%b z=%b, required 00000046 c=1 v=0 z=0",
               o_res[0], o_c[0], o_v[0], o_z[0]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i]} !== 37'h0) begin
        n_fail++;
        $display("FAIL reset_mid cfg%0d: busy=%b done=%b res=%h c=%b v=%b z=%b, required all 0",
                 i, o_busy[i], o_done[i], o_res[i], o_c[i], o_v[i], o_z[i]);
      end
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_done[0] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_mid_done: %0d done pulses, required 0", pulses); end
    // Reset and start together: reset wins.
    t_a = 32'h1; t_b = 32'h1; t_sub = 1'b0; t_start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; t_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_busy[i] !== 1'b0) begin
        n_fail++; $display("FAIL rst_start cfg%0d: busy=%b, required 0", i, o_busy[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int lat[5];
    int seen;
    logic [31:0] a, b;
    logic        s;
    logic [34:0] exp_v;
    for (int it = 0; it < 1000; it++) begin
      a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
      if (it % 8 == 0) b = a;
      if (it % 8 == 1) a = 32'h7FFF_FFFF;
      issue(a, b, s);
      for (int i = 0; i < 5; i++) lat[i] = 0;
      seen = 0;
      for (int c = 1; c <= 40 && seen < 5; c++) begin
        tick();
        for (int i = 0; i < 5; i++)
          if (o_done[i] === 1'b1 && lat[i] == 0) begin lat[i] = c; seen++; end
      end
      for (int i = 0; i < 5; i++) begin
        exp_v = model(cfg_w[i], a, b, s);
        n_checks++;
        if (lat[i] != cfg_n[i]) begin
          n_fail++;
          $display("FAIL sweep_latency cfg%0d it%0d: %0d, required %0d", i, it, lat[i], cfg_n[i]);
        end
        n_checks++;
        if ({o_res[i], o_c[i], o_v[i], o_z[i]} !== exp_v) begin
          n_fail++;
          $display("FAIL sweep_result cfg%0d it%0d a=%h b=%h sub=%b: res=%h c=%b v=%b z=%b, required res=%h c=%b v=%b z=%b",
                   i, it, a, b, s, o_res[i], o_c[i], o_v[i], o_z[i],
                   exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chunked_addsub.md
# chunked_addsub

Multi-cycle, parametrised add/subtract unit for the datapath that processes `CHUNK` bits per clock and carries between chunks through a registered carry. It is the sequential generalisation of the single-bit full adder: same sum/carry equations applied to a `CHUNK`-bit slice, with a start/done handshake, a subtract mode and MIPS-style status flags. It sits beside the ALU, where an area-cheap adder with variable latency is acceptable.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- `WIDTH`, 32: operand and result width. Must be an integer multiple of `CHUNK`.
- `CHUNK`, 8: bits processed per cycle, with 1 ≤ `CHUNK` ≤ `WIDTH`. `N = WIDTH/CHUNK` is the number of compute cycles.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `sub` input 1: 0 computes a+b, 1 computes a−b; sampled with `start`.
- `a` input `WIDTH`: operand A; sampled with `start`.
- `b` input `WIDTH`: operand B; sampled with `start`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when results update.
- `result` output `WIDTH`: sum or difference.
- `c_out` output 1: carry out of the MSB. For subtraction, 1 means no borrow.
- `overflow` output 1: two's-complement signed overflow.
- `zero` output 1: `result` equals 0.

## Operation
State machine:
- **IDLE → RUN** when `start` is high.
  - Latch `a`, latch `b ^ {WIDTH{sub}}`, set the chunk index to 0 and set `carry = sub`.
- **RUN**: each cycle computes chunk `i` (bits `[i*CHUNK +: CHUNK]`).
  - `sum = a_i ^ b_i ^ carry` with a per-bit ripple.
  - The carry out is registered into `carry`.
  - The sum chunk is written into an internal accumulator.
  - `i` increments.
- **RUN → IDLE** after the chunk with `i = N−1`, in the same edge that writes it. On that edge:
  - `result` ← final accumulator value, including the last chunk.
  - `c_out` ← carry out of bit `WIDTH−1`.
  - `overflow` ← carry into bit `WIDTH−1` XOR carry out of bit `WIDTH−1`.
  - `zero` ← (final result == 0).
  - `done` ← 1 for exactly one cycle.

Output behaviour:
- `result` and the flags change only on the completion edge. They hold their values through later busy periods until the next completion.
- `start` while `busy` is ignored and causes no queuing. Operand changes during RUN have no effect.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE. Back-to-back operations therefore need no bubble.
- Arithmetic is modulo 2^`WIDTH`. There is no saturation and no exception output; `overflow` is informational.

## Timing
- **Reset values**: state IDLE, `busy`=0, `done`=0, `result`=0, `c_out`=0, `overflow`=0, `zero`=0. The internal accumulator, carry and index are also cleared.
- **Latency**: `start` sampled high at edge k gives `busy`=1 from edge k to k+N. `done`=1 and new results appear from edge k+N, and `busy`=0 from edge k+N.
- **Throughput**: one operation per N cycles.
- **Reset mid-operation**: `rst` at any RUN edge aborts the operation. The block returns to reset values, with no `done` pulse and no partial result visible.
- **`rst` and `start` together**: `rst` wins and the operation is not accepted.
- **`CHUNK = WIDTH`**: N=1, so `done` comes one edge after `start`.
- **`CHUNK = 1`**: N=`WIDTH`, a pure bit-serial adder.

## Test plan
- **Signed overflow**: `WIDTH`=32, `CHUNK`=8, add 0x7FFFFFFF + 0x00000001 → `result`=0x80000000, `overflow`=1, `c_out`=0, `zero`=0. `done` rises exactly 4 edges after the `start` edge and is high for one cycle.
- **Wrap-around**: add 0xFFFFFFFF + 0x00000001 → `result`=0, `c_out`=1, `zero`=1, `overflow`=0. Subtract 5 − 5 → `result`=0, `c_out`=1, `zero`=1. Subtract 3 − 5 → `result`=0xFFFFFFFE, `c_out`=0.
- **Start while busy**: pulse `start` with new operands 2 cycles into RUN → ignored; the first operation's result is unchanged. Then issue `start` in the `done` cycle → accepted, and the second `done` arrives 4 edges later.
- **Reset mid-operation**: assert `rst` during the 3rd RUN cycle → next cycle all outputs are 0 and `busy`=0, and no `done` is ever seen for the aborted operation.
- **Parameter sweep**: `CHUNK` ∈ {1, 4, 32} at `WIDTH`=32, plus `WIDTH`=16 with `CHUNK`=4. Run 1000 random a, b, sub per configuration and compare against a behavioural (WIDTH+1)-bit reference model for `result`, `c_out`, `overflow` and `zero`. Check that latency equals N each time.
